// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
// Carries the stage register/hazard info in, stall/bubble/forward selects and perf counters out.
interface pipeline_ctrl_if;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        d_use_rs;
  logic        d_use_rt;
  logic        e_wreg;
  logic        e_m2reg;
  logic [4:0]  e_rn;
  logic        m_wreg;
  logic        m_m2reg;
  logic [4:0]  m_rn;
  logic        m_mem_req;
  logic        dmem_ready;
  logic        e_mdu_start;

  logic        f_stall;
  logic        d_stall;
  logic        e_stall;
  logic        m_stall;
  logic        d_bubble;
  logic        e_bubble;
  logic        m_bubble;
  logic        w_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mdu_busy;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_loaduse;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt,
    output e_wreg, e_m2reg, e_rn,
    output m_wreg, m_m2reg, m_rn,
    output m_mem_req, dmem_ready, e_mdu_start,
    input  f_stall, d_stall, e_stall, m_stall,
    input  d_bubble, e_bubble, m_bubble, w_bubble,
    input  fwd_a, fwd_b, mdu_busy,
    input  perf_stall_cycles, perf_loaduse
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt,
    input  e_wreg, e_m2reg, e_rn,
    input  m_wreg, m_m2reg, m_rn,
    input  m_mem_req, dmem_ready, e_mdu_start,
    output f_stall, d_stall, e_stall, m_stall,
    output d_bubble, e_bubble, m_bubble, w_bubble,
    output fwd_a, fwd_b, mdu_busy,
    output perf_stall_cycles, perf_loaduse
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: load-use, data-memory wait and multi-cycle MDU stalls, plus forwarding selects.
// Optional performance counters are compiled in with `define PIPELINE_CTRL_PERF_EN.
//
// state    | meaning
// RUN      | normal flow; load-use stall is evaluated here only
// MEM_WAIT | data memory outstanding; F/D/E/M held, W gets a bubble
// MDU_WAIT | multi-cycle MDU running; F/D/E held, M gets a bubble
module pipeline_ctrl #(
  parameter int unsigned MDU_LAT = 32
) (
  input logic            clk,
  input logic            reset,
  pipeline_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] MDU_LOAD = 8'(MDU_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] mdu_cnt;
  logic [7:0] mdu_cnt_nxt;
  logic       mem_miss;
  logic       load_use;

  logic f_stall, d_stall, e_stall, m_stall;
  logic d_bubble, e_bubble, m_bubble, w_bubble;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] e_rn,
    input logic       m_wreg,
    input logic       m_m2reg,
    input logic [4:0] m_rn
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (src == 5'd0) begin
      sel = 2'd0;
    end else if (e_wreg && !e_m2reg && (e_rn == src)) begin
      sel = 2'd1;
    end else if (m_wreg && (m_rn == src)) begin
      sel = m_m2reg ? 2'd3 : 2'd2;
    end
    return sel;
  endfunction

  always_comb begin
    mem_miss = pif.m_mem_req & ~pif.dmem_ready;
    load_use = pif.e_m2reg & (pif.e_rn != 5'd0) &
               ((pif.d_use_rs & (pif.e_rn == pif.d_rs)) |
                (pif.d_use_rt & (pif.e_rn == pif.d_rt)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mdu_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  // The MDU issue cycle itself is not stalled: the wait is the following
  // MDU_LAT cycles, so busy and the stalls line up exactly.
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    e_stall     = 1'b0;
    m_stall     = 1'b0;
    d_bubble    = 1'b0;
    e_bubble    = 1'b0;
    m_bubble    = 1'b0;
    w_bubble    = 1'b0;

    case (state)
      RUN: begin
        if (mem_miss) begin
          {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
          w_bubble  = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (pif.e_mdu_start) begin
          mdu_cnt_nxt = MDU_LOAD;
          state_nxt   = MDU_WAIT;
        end else if (load_use) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (pif.dmem_ready) begin
          // Release cycle: a held MDU instruction issues now, as from RUN.
          if (pif.e_mdu_start) begin
            mdu_cnt_nxt = MDU_LOAD;
            state_nxt   = MDU_WAIT;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
          w_bubble = 1'b1;
        end
      end

      MDU_WAIT: begin
        {f_stall, d_stall, e_stall} = 3'b111;
        m_bubble = 1'b1;
        if (mdu_cnt == 8'd0) begin
          state_nxt = mem_miss ? MEM_WAIT : RUN;
        end else begin
          mdu_cnt_nxt = mdu_cnt - 8'd1;
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase

    if (reset) begin
      {f_stall, d_stall, e_stall, m_stall}     = 4'b0000;
      {d_bubble, e_bubble, m_bubble, w_bubble} = 4'b0000;
    end
  end

  assign pif.f_stall  = f_stall;
  assign pif.d_stall  = d_stall;
  assign pif.e_stall  = e_stall;
  assign pif.m_stall  = m_stall;
  assign pif.d_bubble = d_bubble;
  assign pif.e_bubble = e_bubble;
  assign pif.m_bubble = m_bubble;
  assign pif.w_bubble = w_bubble;
  assign pif.mdu_busy = (state == MDU_WAIT) & ~reset;

  assign pif.fwd_a = reset ? 2'd0 :
                     fwd_sel(pif.d_rs, pif.e_wreg, pif.e_m2reg, pif.e_rn,
                             pif.m_wreg, pif.m_m2reg, pif.m_rn);
  assign pif.fwd_b = reset ? 2'd0 :
                     fwd_sel(pif.d_rt, pif.e_wreg, pif.e_m2reg, pif.e_rn,
                             pif.m_wreg, pif.m_m2reg, pif.m_rn);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_lu_q;

  // e_bubble is only ever raised by a load-use stall, so it marks those cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_lu_q    <= 32'd0;
    end else begin
      if (f_stall)  perf_stall_q <= perf_stall_q + 32'd1;
      if (e_bubble) perf_lu_q    <= perf_lu_q + 32'd1;
    end
  end

  assign pif.perf_stall_cycles = perf_stall_q;
  assign pif.perf_loaduse      = perf_lu_q;
`else
  assign pif.perf_stall_cycles = 32'd0;
  assign pif.perf_loaduse      = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MDU_LAT=5): stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares every cycle.
module tb_pipeline_ctrl;

  localparam int unsigned LAT = 5;
`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic       e_wreg;
    logic       e_m2reg;
    logic [4:0] e_rn;
    logic       m_wreg;
    logic       m_m2reg;
    logic [4:0] m_rn;
    logic       m_mem_req;
    logic       dmem_ready;
    logic       e_mdu_start;
  } vec_t;

  typedef struct {
    logic [12:0] flags;
    logic [31:0] ps;
    logic [31:0] pl;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.MDU_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_s  = 32'd0;
  logic [31:0] acc_l  = 32'd0;

  // flags layout: {f,d,e,m stall}{d,e,m,w bubble}{fwd_a}{fwd_b}{mdu_busy}
  function automatic logic [12:0] fl(input logic [3:0] st, input logic [3:0] bb,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic busy);
    return {st, bb, fa, fb, busy};
  endfunction

  localparam logic [12:0] X_NONE = 13'd0;
  localparam logic [12:0] X_LU   = {4'b1100, 4'b0100, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] X_MEM  = {4'b1111, 4'b0001, 2'd0, 2'd0, 1'b0};
  localparam logic [12:0] X_MDU  = {4'b1110, 4'b0010, 2'd0, 2'd0, 1'b1};

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    return v;
  endfunction

  task automatic apply(input vec_t v, input logic [12:0] fexp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = v.rst;
    pif.d_rs        = v.d_rs;
    pif.d_rt        = v.d_rt;
    pif.d_use_rs    = v.d_use_rs;
    pif.d_use_rt    = v.d_use_rt;
    pif.e_wreg      = v.e_wreg;
    pif.e_m2reg     = v.e_m2reg;
    pif.e_rn        = v.e_rn;
    pif.m_wreg      = v.m_wreg;
    pif.m_m2reg     = v.m_m2reg;
    pif.m_rn        = v.m_rn;
    pif.m_mem_req   = v.m_mem_req;
    pif.dmem_ready  = v.dmem_ready;
    pif.e_mdu_start = v.e_mdu_start;
    e.flags = fexp;
    e.ps    = PERF_EN ? acc_s : 32'd0;
    e.pl    = PERF_EN ? acc_l : 32'd0;
    e.name  = name;
    sb_q.push_back(e);
    if (v.rst) begin
      acc_s = 32'd0;
      acc_l = 32'd0;
    end else begin
      acc_s = acc_s + 32'(fexp[12]);
      acc_l = acc_l + 32'(fexp[7]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t        e;
        logic [12:0] obs;
        e   = sb_q.pop_front();
        obs = {pif.f_stall, pif.d_stall, pif.e_stall, pif.m_stall,
               pif.d_bubble, pif.e_bubble, pif.m_bubble, pif.w_bubble,
               pif.fwd_a, pif.fwd_b, pif.mdu_busy};
        checks++;
        if (obs !== e.flags) begin
          errors++;
          $display("FAIL %s flags: got %b expected %b", e.name, obs, e.flags);
        end
        checks++;
        if ((pif.perf_stall_cycles !== e.ps) || (pif.perf_loaduse !== e.pl)) begin
          errors++;
          $display("FAIL %s perf: got stall=%0d lu=%0d expected stall=%0d lu=%0d",
                   e.name, pif.perf_stall_cycles, pif.perf_loaduse, e.ps, e.pl);
        end
      end
    end
  end

  initial begin
    vec_t v;
    reset           = 1'b1;
    pif.d_rs        = 5'd0;
    pif.d_rt        = 5'd0;
    pif.d_use_rs    = 1'b0;
    pif.d_use_rt    = 1'b0;
    pif.e_wreg      = 1'b0;
    pif.e_m2reg     = 1'b0;
    pif.e_rn        = 5'd0;
    pif.m_wreg      = 1'b0;
    pif.m_m2reg     = 1'b0;
    pif.m_rn        = 5'd0;
    pif.m_mem_req   = 1'b0;
    pif.dmem_ready  = 1'b0;
    pif.e_mdu_start = 1'b0;

    // Reset holds every output low even with all hazards present
    v = idle(); v.rst = 1'b1; v.e_mdu_start = 1'b1; v.m_mem_req = 1'b1;
    v.e_wreg = 1'b1; v.e_m2reg = 1'b1; v.e_rn = 5'd3; v.d_rs = 5'd3; v.d_use_rs = 1'b1;
    v.m_wreg = 1'b1; v.m_rn = 5'd3;
    apply(v, X_NONE, "reset_outputs");
    apply(idle(), X_NONE, "idle_after_reset");

    // lw $3 in E, D reads $3: one-cycle load-use, then load data forwarded from M
    v = idle(); v.e_wreg = 1'b1; v.e_m2reg = 1'b1; v.e_rn = 5'd3; v.d_rs = 5'd3; v.d_use_rs = 1'b1;
    apply(v, X_LU, "loaduse_rs");
    v = idle(); v.m_wreg = 1'b1; v.m_m2reg = 1'b1; v.m_rn = 5'd3; v.d_rs = 5'd3; v.d_use_rs = 1'b1;
    apply(v, fl(4'b0, 4'b0, 2'd3, 2'd0, 1'b0), "fwd_a_load");

    v = idle(); v.e_wreg = 1'b1; v.e_m2reg = 1'b1; v.e_rn = 5'd9; v.d_rt = 5'd9; v.d_use_rt = 1'b1;
    v.d_rs = 5'd9;
    apply(v, X_LU, "loaduse_rt");
    v = idle(); v.e_wreg = 1'b1; v.e_m2reg = 1'b1; v.e_rn = 5'd9; v.d_rt = 5'd9;
    apply(v, X_NONE, "no_use_no_stall");
    v = idle(); v.e_wreg = 1'b1; v.e_m2reg = 1'b1; v.e_rn = 5'd0; v.d_rs = 5'd0; v.d_use_rs = 1'b1;
    apply(v, X_NONE, "r0_no_stall");

    // Forwarding: E beats M; register 0 never forwarded
    v = idle(); v.e_wreg = 1'b1; v.e_rn = 5'd7; v.m_wreg = 1'b1; v.m_rn = 5'd7; v.d_rt = 5'd7;
    apply(v, fl(4'b0, 4'b0, 2'd0, 2'd1, 1'b0), "fwd_b_e_prio");
    v = idle(); v.m_wreg = 1'b1; v.m_rn = 5'd12; v.d_rs = 5'd12; v.e_wreg = 1'b1; v.e_rn = 5'd5;
    v.d_rt = 5'd5;
    apply(v, fl(4'b0, 4'b0, 2'd2, 2'd1, 1'b0), "fwd_m_alu_e_alu");
    v = idle(); v.e_rn = 5'd4; v.m_wreg = 1'b1; v.m_m2reg = 1'b1; v.m_rn = 5'd4;
    v.d_rs = 5'd4; v.d_rt = 5'd4;
    apply(v, fl(4'b0, 4'b0, 2'd3, 2'd3, 1'b0), "fwd_e_nowrite");
    v = idle(); v.m_wreg = 1'b1; v.m_rn = 5'd0; v.e_wreg = 1'b1; v.e_rn = 5'd0;
    apply(v, X_NONE, "fwd_r0");

    // Data memory waits 4 cycles, completes on the 5th
    v = idle(); v.m_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) apply(v, X_MEM, "mem_wait");
    v.dmem_ready = 1'b1;
    apply(v, X_NONE, "mem_release");
    apply(v, X_NONE, "mem_hit");
    apply(idle(), X_NONE, "idle_after_mem");

    // MDU pulse: busy and stalls for LAT cycles after issue
    v = idle(); v.e_mdu_start = 1'b1;
    apply(v, X_NONE, "mdu_issue");
    for (int i = 0; i < 5; i++) apply(idle(), X_MDU, "mdu_wait");
    apply(idle(), X_NONE, "mdu_done");

    // Priority: miss beats MDU beats load-use; MDU issues on memory release
    v = idle(); v.m_mem_req = 1'b1; v.e_mdu_start = 1'b1;
    v.e_m2reg = 1'b1; v.e_rn = 5'd3; v.d_rs = 5'd3; v.d_use_rs = 1'b1;
    apply(v, X_MEM, "prio_mem_first");
    v.dmem_ready = 1'b1;
    apply(v, X_NONE, "prio_mem_release");
    for (int i = 0; i < 5; i++) apply(idle(), X_MDU, "prio_mdu_wait");
    apply(idle(), X_NONE, "prio_done");

    // Miss appearing during MDU_WAIT waits for the counter, then MEM_WAIT
    v = idle(); v.e_mdu_start = 1'b1;
    apply(v, X_NONE, "mdu2_issue");
    v = idle(); v.m_mem_req = 1'b1;
    for (int i = 0; i < 5; i++) apply(v, X_MDU, "mdu2_wait_miss");
    apply(v, X_MEM, "mdu2_then_mem");
    v.dmem_ready = 1'b1;
    apply(v, X_NONE, "mdu2_mem_release");

    // Reset in the middle of MDU_WAIT
    v = idle(); v.e_mdu_start = 1'b1;
    apply(v, X_NONE, "mdu3_issue");
    apply(idle(), X_MDU, "mdu3_wait");
    apply(idle(), X_MDU, "mdu3_wait");
    v = idle(); v.rst = 1'b1; v.e_mdu_start = 1'b1;
    apply(v, X_NONE, "mdu3_reset");
    apply(idle(), X_NONE, "after_reset_run");
    v = idle(); v.e_wreg = 1'b1; v.e_m2reg = 1'b1; v.e_rn = 5'd20; v.d_rt = 5'd20; v.d_use_rt = 1'b1;
    apply(v, X_LU, "loaduse_after_reset");
    apply(idle(), X_NONE, "final_idle");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 32: cycles a multi-cycle multiply/divide holds the E stage (range 2..255).
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 d_rs, d_rt  in  5 each  D-stage source register numbers; d_use_rs, d_use_rt  in  1 each  source actually read.
REQ-005 e_wreg, e_m2reg  in  1 each; e_rn  in  5  E-stage destination, register write and load flags.
REQ-006 m_wreg, m_m2reg  in  1 each; m_rn  in  5  M-stage destination, register write and load flags.
REQ-007 m_mem_req  in  1  M stage accesses data memory; dmem_ready  in  1  data memory completes this cycle.
REQ-008 e_mdu_start  in  1  E holds a multi-cycle MDU instruction.
REQ-009 f_stall, d_stall, e_stall, m_stall  out  1 each  hold the named pipeline register.
REQ-010 d_bubble, e_bubble, m_bubble, w_bubble  out  1 each  load the register's bubble value.
REQ-011 fwd_a, fwd_b  out  2 each  operand source: 0 regfile, 1 E ALU result, 2 M ALU result, 3 M load data.
REQ-012 mdu_busy  out  1  MDU wait in progress; perf_stall_cycles, perf_loaduse  out  32 each  counters (REQ-026).

Function
REQ-013 States RUN, MEM_WAIT, MDU_WAIT; stall/bubble outputs are combinational from state and inputs.
REQ-014 Stall and bubble for the same stage are never both asserted in any cycle.
REQ-015 Load-use hazard = RUN & e_m2reg & e_rn!=0 & ((d_use_rs & e_rn==d_rs) | (d_use_rt & e_rn==d_rt)); it asserts f_stall, d_stall, e_bubble for exactly one cycle, and the state stays RUN.
REQ-016 RUN -> MEM_WAIT when m_mem_req & !dmem_ready; MEM_WAIT asserts f/d/e/m_stall and w_bubble; MEM_WAIT -> RUN on the cycle dmem_ready=1, with all stalls deasserted in that cycle.
REQ-017 A miss resolved in the same cycle it is requested (dmem_ready=1) causes no stall.
REQ-018 RUN -> MDU_WAIT when e_mdu_start and no memory wait; an 8-bit counter loads MDU_LAT-1; MDU_WAIT asserts f/d/e_stall and m_bubble, decrements the counter each cycle, and returns to RUN after the counter reaches 0, for a total stall of MDU_LAT cycles.
REQ-019 Priority: memory wait > MDU start > load-use; the lower event is held (E frozen) and taken after the higher event clears.
REQ-020 A memory miss arising during MDU_WAIT: MDU_WAIT keeps counting; once the counter reaches 0, MEM_WAIT is entered if the miss remains.
REQ-021 mdu_busy = (state==MDU_WAIT).
REQ-022 Forwarding per operand: register 0 always 0; E match & e_wreg & !e_m2reg -> 1; else M match & m_wreg -> 3 if m_m2reg else 2; else 0; E takes precedence over M.

Reset
REQ-023 Reset forces state RUN, MDU counter 0 and perf counters 0 on the next clk edge; reset overrides any in-flight wait.
REQ-024 While reset=1, all stall and bubble outputs are 0, mdu_busy=0 and fwd_a=fwd_b=0.

Configuration
REQ-025 Macro PIPELINE_CTRL_PERF_EN compiles in the performance counters.
REQ-026 With the macro defined: perf_stall_cycles increments on any cycle where f_stall=1; perf_loaduse increments per load-use cycle; both wrap at 2^32. Without the macro: both outputs are tied to 0 and no counter flops exist.

Verification
REQ-027 lw $3 in E, D reads $3 (d_use_rs=1) -> one cycle f_stall=d_stall=e_bubble=1, then fwd_a=3.
REQ-028 m_mem_req=1, dmem_ready low 4 cycles -> f/d/e/m_stall=1 and w_bubble=1 for 4 cycles, then 0.
REQ-029 MDU_LAT=5, e_mdu_start pulse -> mdu_busy and f/d/e_stall high 5 cycles, m_bubble high 5 cycles.
REQ-030 e_rn=m_rn=7, both write ALU, d_rt=7 -> fwd_b=1; d_rs=0 with e_rn=0 -> fwd_a=0.
REQ-031 Reset asserted mid MDU_WAIT -> next cycle state RUN, mdu_busy=0, counters 0 (with PIPELINE_CTRL_PERF_EN defined).
